register_write_arbiter: RTL and testbench
=========================================

# register_write_arbiter

Round-robin write arbiter that shares one `WIDTH`-bit load-enabled register among `NREQ` requesters. It sits directly in front of the register's `load`/`d` inputs and turns each granted request into exactly one single-cycle load pulse. Consecutive loads are separated by a programmable quiet gap. It guarantees one writer per load, no starvation, and a deterministic post-reset state.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `WIDTH`, 4: data width of the shared register.
- `HOLD_CYCLES`, 2: idle cycles forced after every load (0..15).

- `clk`  in  1  rising-edge clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `req`  in  `NREQ`  per-requester write request, level.
- `wdata`  in  `NREQ*WIDTH`  packed write data; requester i at `[i*WIDTH +: WIDTH]`.
- `gnt`  out  `NREQ`  one-hot grant pulse, one cycle, coincident with `load`.
- `load`  out  1  to register `load`.
- `d`  out  `WIDTH`  to register `d`.
- `busy`  out  1  high whenever state is not IDLE.
- `owner`  out  `$clog2(NREQ)`  index of the most recent winner.

## Operation
- **States:**
  - **IDLE:** evaluates `req`.
  - **WRITE:** load cycle, exactly one cycle.
  - **GAP:** `HOLD_CYCLES` cycles, skipped when `HOLD_CYCLES`=0.
- **IDLE:**
  - At an edge with `req` != 0, pick the winner by round-robin, searching upward from `ptr` and wrapping at `NREQ`-1 to 0.
  - At that edge register: `load`<=1, `d`<=`wdata[win]`, `gnt`<=onehot(win), `owner`<=win, `ptr`<=(win+1) mod `NREQ`, state<=WRITE.
  - At an edge with `req` == 0, all outputs stay in their idle values (`load`=0, `gnt`=0); `d` and `owner` hold.
- **WRITE:**
  - Next edge: `load`<=0, `gnt`<=0.
  - State<=GAP with counter=`HOLD_CYCLES`-1, or <=IDLE when `HOLD_CYCLES`=0.
- **GAP:** counter decrements each edge; IDLE is entered at the edge where counter==0.
- **`req` handling:** ignored in WRITE and GAP. No request is lost: a pending `req` is simply evaluated at the next IDLE edge.
- **Requester contract:**
  - Hold `req` and `wdata` stable until `gnt[i]` is seen.
  - Deassert `req` (or present new data) by the edge that ends the `gnt` cycle.
- **Fairness:** with all requesters continuously requesting, grants rotate 0,1,…,`NREQ`-1,0,…. Any requester waits at most `NREQ`-1 other grants.
- **`d`:** holds its last value when `load`=0. The register ignores it then.
- **`ptr`:** internal, `$clog2(NREQ)` bits, wraps modulo `NREQ`. Its reset value is 0.
- **Reset (`rstn`=0, any time, including mid-WRITE or mid-GAP):**
  - Immediately, without waiting for a clock: `load`=0, `gnt`=0, `d`=0, `owner`=0, `busy`=0, state=IDLE, `ptr`=0, counter=0.
  - A load pulse that was in flight is cancelled; the register sees no load.
  - After `rstn` rises, the first evaluation happens at the next rising edge.

## Timing
- **Request-to-load latency:** `req` sampled high at IDLE edge E gives `load`/`gnt` high during cycle [E, E+1). The register captures `d` at edge E+1.
- **`busy`:** high from E to E+1+`HOLD_CYCLES` (1+`HOLD_CYCLES` cycles). It is low during the IDLE cycle that precedes the next evaluation.
- **Minimum load-to-load spacing:** `HOLD_CYCLES`+2 cycles, i.e. 4 at default and 2 at `HOLD_CYCLES`=0.
- **Registered outputs:** all outputs come from flops. There is no combinational path from `req`/`wdata` to any output.
- **`load` shape:** never high for two consecutive cycles.
- **`gnt`:** always one-hot or zero.

## Test plan
- **Reset:** `rstn`=0 with `req`=4'b1111 → `load`=0, `gnt`=0, `d`=0, `owner`=0, `busy`=0. This must hold immediately and on every clock edge.
- **Single request:** `req`=4'b0010, `wdata[1]`=5 at IDLE edge E → during [E,E+1) `gnt`=4'b0010, `load`=1, `d`=5. `busy` is high for 3 cycles. Register q=5 after E+1.
- **Full contention:** `req`=4'b1111 with data 1,2,3,4; each requester drops `req` after its own `gnt` → grants 0,1,2,3 in order, `d`=1,2,3,4. Load pulses are exactly 4 cycles apart.
- **Fairness:** `req[0]` re-asserted immediately after each grant with data 7, `req[2]` held with data 9 → grants alternate 0,2,0,2. `req[2]` is granted no later than its second evaluation.
- **Reset mid-operation:** assert `rstn`=0 during GAP after the grant to requester 1 (`ptr`=2) → outputs go to 0 asynchronously. After release with `req`=4'b0110, requester 1 wins because `ptr` was reset to 0.
- **Zero-gap variant:** `HOLD_CYCLES`=0 with `req`=4'b0011, data 3 and 12, dropped on `gnt` → loads 3 then 12, exactly 2 cycles apart. `busy` is high only during the load cycles.

Source files
------------

// File: rtl/register_write_arbiter.sv
// -----------------------------------------------------------------------------
// register_write_arbiter
//
// Round-robin write arbiter in front of a single WIDTH-bit load-enabled
// register shared by NREQ requesters. Every granted request becomes exactly
// one single-cycle load pulse, followed by HOLD_CYCLES forced idle cycles
// before the next request is evaluated.
//
// Parameters
//   NREQ        number of requesters (2..8)
//   WIDTH       data width of the shared register
//   HOLD_CYCLES idle cycles forced after every load (0..15)
//
// Ports
//   clk    in   rising-edge clock
//   rstn   in   asynchronous active-low reset
//   req    in   [NREQ]        per-requester write request (level)
//   wdata  in   [NREQ*WIDTH]  packed write data, requester i at [i*WIDTH +: WIDTH]
//   gnt    out  [NREQ]        one-hot grant pulse, coincident with load
//   load   out                register load strobe
//   d      out  [WIDTH]       register data, holds its value while load=0
//   busy   out                high whenever the arbiter is not idle
//   owner  out  [clog2(NREQ)] index of the most recent winner
//
// All outputs are registered; there is no combinational path from req/wdata
// to any output.
// -----------------------------------------------------------------------------
module register_write_arbiter #(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  output logic [NREQ-1:0]         gnt,
  output logic                    load,
  output logic [WIDTH-1:0]        d,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] owner
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [IW-1:0] ptr;

  // Round-robin winner search, starting at ptr and wrapping at NREQ-1.
  logic [IW-1:0] win;
  logic [IW-1:0] win_next;
  logic          found;
  int            idx;
  int            nxt;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx[IW-1:0]]) begin
        win   = idx[IW-1:0];
        found = 1'b1;
      end
    end
    nxt = int'(win) + 1;
    if (nxt >= NREQ) nxt = 0;
    win_next = nxt[IW-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // The data register is reset too: d=0 after reset is observable.
      state <= IDLE;
      cnt   <= '0;
      ptr   <= '0;
      gnt   <= '0;
      load  <= 1'b0;
      d     <= '0;
      busy  <= 1'b0;
      owner <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            load  <= 1'b1;
            d     <= wdata[win*WIDTH +: WIDTH];
            gnt   <= NREQ'(1) << win;
            owner <= win;
            ptr   <= win_next;
            busy  <= 1'b1;
            state <= WRITE;
          end
        end

        WRITE: begin
          load <= 1'b0;
          gnt  <= '0;
          if (HOLD_CYCLES == 0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt   <= 4'(HOLD_CYCLES - 1);
            state <= GAP;
          end
        end

        GAP: begin
          if (cnt == 4'd0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        default: begin
          load  <= 1'b0;
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_register_write_arbiter
//
// Two instances share clk/rstn: u_dut with default parameters (NREQ=4,
// WIDTH=4, HOLD_CYCLES=2) and u_z with HOLD_CYCLES=0. A table of single
// arbitration rounds with hand-computed results is applied first, then
// hand-written sequences cover contention, fairness, reset mid-operation
// and the zero-gap variant.
// -----------------------------------------------------------------------------
module tb_register_write_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;

  logic [3:0]  req;
  logic [15:0] wdata;
  logic [3:0]  gnt;
  logic        load;
  logic [3:0]  d;
  logic        busy;
  logic [1:0]  owner;

  logic [3:0]  req_z;
  logic [15:0] wdata_z;
  logic [3:0]  gnt_z;
  logic        load_z;
  logic [3:0]  d_z;
  logic        busy_z;
  logic [1:0]  owner_z;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  register_write_arbiter #(.NREQ(4), .WIDTH(4), .HOLD_CYCLES(2)) u_dut (
    .clk(clk), .rstn(rstn), .req(req), .wdata(wdata),
    .gnt(gnt), .load(load), .d(d), .busy(busy), .owner(owner)
  );

  register_write_arbiter #(.NREQ(4), .WIDTH(4), .HOLD_CYCLES(0)) u_z (
    .clk(clk), .rstn(rstn), .req(req_z), .wdata(wdata_z),
    .gnt(gnt_z), .load(load_z), .d(d_z), .busy(busy_z), .owner(owner_z)
  );

  typedef struct {
    logic [3:0]  req;
    logic [15:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  d;
    logic [1:0]  owner;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_load"},  load,  0);
    check({tag, "_gnt"},   gnt,   0);
    check({tag, "_d"},     d,     0);
    check({tag, "_owner"}, owner, 0);
    check({tag, "_busy"},  busy,  0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    req  = '0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // One arbitration round from IDLE: grant, then the quiet gap.
  task automatic run_vec(input vec_t v, input int i);
    int nb;
    @(negedge clk);
    req   = v.req;
    wdata = v.wdata;
    @(posedge clk); #1;
    check($sformatf("vec%0d_load", i),  load,  1);
    check($sformatf("vec%0d_gnt", i),   gnt,   v.gnt);
    check($sformatf("vec%0d_d", i),     d,     v.d);
    check($sformatf("vec%0d_owner", i), owner, v.owner);
    check($sformatf("vec%0d_busy", i),  busy,  1);
    @(negedge clk);
    req = '0;
    nb  = 1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (!busy) break;
      nb++;
      check($sformatf("vec%0d_gap_load", i), load, 0);
      check($sformatf("vec%0d_gap_gnt", i),  gnt,  0);
    end
    check($sformatf("vec%0d_busy_len", i), nb, 3);
    check($sformatf("vec%0d_d_hold", i), d, v.d);
  endtask

  logic [3:0] lg[4];
  logic [3:0] ld[4];
  int         lt[4];
  int         n;

  initial begin
    // ptr sequence (after reset, ptr=0): 0 ->2 ->3 ->1 ->0 ->1 ->3 ->1 ->2
    vecs[0] = '{4'b0010, 16'h0050, 4'b0010, 4'h5, 2'd1};
    vecs[1] = '{4'b1111, 16'h4321, 4'b0100, 4'h3, 2'd2};
    vecs[2] = '{4'b0001, 16'h000A, 4'b0001, 4'hA, 2'd0};
    vecs[3] = '{4'b1001, 16'hB00C, 4'b1000, 4'hB, 2'd3};
    vecs[4] = '{4'b1001, 16'hB00C, 4'b0001, 4'hC, 2'd0};
    vecs[5] = '{4'b0100, 16'h0E00, 4'b0100, 4'hE, 2'd2};
    vecs[6] = '{4'b0011, 16'h00F7, 4'b0001, 4'h7, 2'd0};
    vecs[7] = '{4'b1110, 16'h1230, 4'b0010, 4'h3, 2'd1};

    req     = 4'hF;
    wdata   = 16'hFFFF;
    req_z   = '0;
    wdata_z = '0;

    // Reset with all requests high: zero immediately and on every edge.
    #2 rstn = 1'b0;
    #1;
    check_zero("rst_imm");
    check("rst_imm_busy_z", busy_z, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_zero($sformatf("rst_edge%0d", k));
    end
    @(negedge clk);
    req  = '0;
    rstn = 1'b1;

    // Table of single rounds.
    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Full contention: each requester drops req after its own grant.
    pulse_reset();
    req   = 4'hF;
    wdata = 16'h4321;
    n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(posedge clk); #1;
      if (load) begin
        lg[n] = gnt; ld[n] = d; lt[n] = cyc; n++;
      end
      @(negedge clk);
      req = req & ~gnt;
    end
    check("cont_count", n, 4);
    for (int k = 0; k < n; k++) begin
      check($sformatf("cont_gnt%0d", k), lg[k], 32'(1) << k);
      check($sformatf("cont_d%0d", k), ld[k], k + 1);
      if (k > 0) check($sformatf("cont_space%0d", k), lt[k] - lt[k-1], 4);
    end
    repeat (4) @(negedge clk);

    // Fairness: req[0] re-asserted right after each grant, req[2] held.
    pulse_reset();
    req   = 4'b0101;
    wdata = 16'h0907;
    n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(posedge clk); #1;
      if (load) begin
        lg[n] = gnt; ld[n] = d; lt[n] = cyc; n++;
      end
      @(negedge clk);
      req[0] = !gnt[0];
    end
    req = '0;
    check("fair_count", n, 4);
    for (int k = 0; k < n; k++) begin
      check($sformatf("fair_gnt%0d", k), lg[k], (k % 2 == 0) ? 4'b0001 : 4'b0100);
      check($sformatf("fair_d%0d", k), ld[k], (k % 2 == 0) ? 4'h7 : 4'h9);
    end
    repeat (4) @(negedge clk);

    // Reset during GAP after grant to requester 1 (ptr=2).
    pulse_reset();
    req   = 4'b0010;
    wdata = 16'h0050;
    @(posedge clk); #1;
    check("mid_gnt", gnt, 4'b0010);
    @(negedge clk);
    req = '0;
    @(posedge clk); #3;
    check("mid_in_gap_busy", busy, 1);
    rstn = 1'b0;
    #1;
    check_zero("mid_rst");
    req   = 4'b0110;
    wdata = 16'h0860;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("mid_after_gnt", gnt, 4'b0010);
    check("mid_after_d", d, 4'h6);
    check("mid_after_owner", owner, 1);
    @(negedge clk);
    req = '0;
    repeat (4) @(negedge clk);

    // Reset during the load cycle cancels the pulse.
    req   = 4'b0001;
    wdata = 16'h000A;
    @(posedge clk); #1;
    check("cancel_load_pre", load, 1);
    #2 rstn = 1'b0;
    #1;
    check_zero("cancel_rst");
    @(negedge clk);
    req  = '0;
    rstn = 1'b1;
    @(posedge clk); #1;
    check("cancel_after_load", load, 0);

    // Zero-gap instance: loads 2 cycles apart, busy only with load.
    @(negedge clk);
    req_z   = 4'b0011;
    wdata_z = 16'h00C3;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      check($sformatf("zero_busy_c%0d", c), busy_z, load_z);
      if (load_z && n < 4) begin
        lg[n] = gnt_z; ld[n] = d_z; lt[n] = cyc; n++;
      end
      @(negedge clk);
      req_z = req_z & ~gnt_z;
    end
    check("zero_count", n, 2);
    if (n == 2) begin
      check("zero_gnt0", lg[0], 4'b0001);
      check("zero_d0", ld[0], 4'h3);
      check("zero_gnt1", lg[1], 4'b0010);
      check("zero_d1", ld[1], 4'hC);
      check("zero_space", lt[1] - lt[0], 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends with a summary.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
